// File: rtl/input_pkg.sv
// Shared constants and button indices for the button conditioner.
// Defaults: 10 ms debounce, 300 ms repeat delay and 100 ms repeat period, all at 148.5 MHz.
package input_pkg;

  localparam int CLK_FREQ_HZ         = 148500000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 100;
  localparam int REPEAT_DELAY_DEF    = (CLK_FREQ_HZ / 10) * 3;
  localparam int REPEAT_PERIOD_DEF   = CLK_FREQ_HZ / 10;

  typedef enum int unsigned {
    LEFT,
    RIGHT,
    DOWN,
    ROT_CW,
    ROT_CCW,
    DROP,
    PAUSE
  } button_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce window, edge pulses and optional auto-repeat.
// A held change reaches level on edge DEBOUNCE_CYCLES+3; BUTTON_CONDITIONER_AUTO_REPEAT_EN enables repeat.
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic noisy,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_channel: timing parameters must be at least 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          cand;
  logic [CW-1:0] cnt;
  logic          settled;
  logic          level_next;

  assign settled    = (sync[1] == cand) && (cnt == CNT_LAST);
  assign level_next = settled ? cand : level;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync  <= '0;
      cand  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], noisy};
      if (sync[1] != cand) begin
        cand <= sync[1];
        cnt  <= '0;
      end else if (!settled) begin
        cnt <= cnt + CW'(1);
      end
      level <= level_next;
      rise  <= level_next & ~level;
      fall  <= ~level_next & level;
    end
  end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          periodic;
  logic          held;
  logic          due;

  // Counting only while held on both sides of the edge keeps the press and release cycles at zero.
  assign held = level & level_next;
  assign due  = (rcnt == (periodic ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rcnt     <= '0;
      periodic <= 1'b0;
      rpt      <= 1'b0;
    end else if (held) begin
      if (due) begin
        rcnt     <= '0;
        periodic <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      rpt <= due;
    end else begin
      rcnt     <= '0;
      periodic <= 1'b0;
      rpt      <= 1'b0;
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Array of independent debounced buttons with press/release/repeat pulses.
// Repeat pulses exist only when BUTTON_CONDITIONER_AUTO_REPEAT_EN is defined; otherwise repeat_out is 0.
module button_conditioner
  import input_pkg::*;
#(
  parameter int NUM_CH          = 7,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [NUM_CH-1:0] noisy_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] repeat_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .noisy    (noisy_in[i]),
      .level    (clean_out[i]),
      .rise     (press_out[i]),
      .fall     (release_out[i]),
      .rpt      (repeat_out[i])
    );
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_CH, default 7: number of independent button channels, at least 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1485000: stability window in clk_in cycles (10 ms at 148.5 MHz), at least 1.
REQ-003 Parameter REPEAT_DELAY, default 44550000: clk_in cycles from press pulse to first repeat pulse (300 ms), at least 1.
REQ-004 Parameter REPEAT_PERIOD, default 14850000: clk_in cycles between subsequent repeat pulses (100 ms), at least 1.
REQ-005 clk_in  input  1  sole clock; all state on its rising edge.
REQ-006 reset_in  input  1  one clock; reset is asynchronous and active-high.
REQ-007 noisy_in  input  NUM_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 clean_out  output  NUM_CH  debounced level per channel.
REQ-009 press_out  output  NUM_CH  one-cycle pulse on each debounced 0->1 transition.
REQ-010 release_out  output  NUM_CH  one-cycle pulse on each debounced 1->0 transition.
REQ-011 repeat_out  output  NUM_CH  one-cycle auto-repeat pulse while held.

Function
REQ-012 Each noisy_in bit shall pass through a 2-flop synchroniser before any other logic uses it; channels shall be fully independent.
REQ-013 Per channel: if synchronised input differs from candidate register, candidate takes the new value and counter clears to 0; otherwise, if counter equals DEBOUNCE_CYCLES-1, clean_out takes candidate and counter holds; otherwise counter increments.
REQ-014 Latency: a noisy_in change held stable shall appear on clean_out at exactly the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new value as edge 1.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles shall leave clean_out unchanged and restart the window.
REQ-016 press_out[i] / release_out[i] shall be high in exactly the one cycle where clean_out[i] holds its new value for the first time; both are registered and never high together.
REQ-017 Counter width shall be $clog2(DEBOUNCE_CYCLES+1), with no wrap: the count saturates at DEBOUNCE_CYCLES-1.
REQ-018 Repeat: the repeat counter clears in the press_out cycle. repeat_out[i] shall pulse REPEAT_DELAY cycles after press_out[i], then every REPEAT_PERIOD cycles while clean_out[i]=1.
REQ-019 Release clears the repeat counter in the release_out cycle. repeat_out shall never be high in the release_out cycle or while clean_out=0.
REQ-020 Simultaneous channel events shall produce their pulses in the same cycle without arbitration.

Reset
REQ-021 reset_in high shall asynchronously clear synchronisers, candidates, all counters, clean_out, press_out, release_out and repeat_out to 0.
REQ-022 Reset mid-press shall drop clean_out to 0 without a release_out pulse. A button held through reset shall produce press_out after REQ-014 latency measured from reset deassertion.

Configuration
REQ-023 Macro BUTTON_CONDITIONER_AUTO_REPEAT_EN defined: the repeat counters and REQ-018/019 behaviour shall be compiled in.
REQ-024 Macro absent: repeat logic shall be absent, the repeat_out port shall remain present and tie to all zeros, and all other behaviour shall be unchanged.

Structure
REQ-025 Package input_pkg shall hold default constants CLK_FREQ_HZ=148500000, DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF and a button index enum (LEFT, RIGHT, DOWN, ROT_CW, ROT_CCW, DROP, PAUSE).
REQ-026 Per-channel logic shall be a sub-module button_channel, instantiated NUM_CH times by generate; the top shall contain only the instantiation and output wiring.

Verification
Use NUM_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, with the macro defined unless stated.
REQ-027 Clean press: noisy_in[0] rises and holds -> clean_out[0] and press_out[0] rise at edge 7; press_out is high for exactly 1 cycle.
REQ-028 Bounce: noisy_in[0] toggles high for 3 cycles, low for 1, then high steadily -> single press_out at edge 7 after the final rise; no earlier clean_out change.
REQ-029 Hold: press held 30 cycles -> repeat_out[0] at 10, 13, 16, 19, 22, 25, 28 cycles after press_out. Release -> release_out once, no repeat in that cycle.
REQ-030 Independence: ch0 and ch1 pressed on the same edge -> press_out=2'b11 in one cycle. Ch1 bouncing does not perturb ch0.
REQ-031 Reset mid-hold: assert reset_in asynchronously between edges -> all outputs 0 immediately, no release_out. With the button still held, press_out 7 edges after deassertion.
REQ-032 Macro absent: the REQ-029 stimulus gives repeat_out=0 throughout, and press/release timing is identical.
